// File: rtl/modulo_compuerta2_pkg.sv
// Shared constants, operand bundle and parity helper for the modulo_compuerta2 gate block.
package modulo_compuerta2_pkg;

    localparam int SYNC_STAGES_MAX = 3;
    localparam int TOGGLE_CNT_W    = 8;
    localparam logic [TOGGLE_CNT_W-1:0] TOGGLE_CNT_MAX = 8'd255;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } operands_t;

    function automatic logic parity4(input operands_t ops);
        return ops.a ^ ops.b ^ ops.c ^ ops.d;
    endfunction

endpackage

// File: rtl/modulo_compuerta2_logic.sv
// Pure combinational core: AND-OR term and four-input parity of one operand set.
module modulo_compuerta2_logic
    import modulo_compuerta2_pkg::*;
(
    input  operands_t ops,
    output logic      x_c,
    output logic      y_c
);

    // Core gate equations
    always_comb begin
        x_c = (ops.a & ops.b) | (ops.c & ops.d);
        y_c = parity4(ops);
    end

endmodule

// File: rtl/modulo_compuerta2.sv
// Top: optional input synchronizers, optional output registers and, with
// MODULO_COMPUERTA2_TOGGLE_CNT_EN defined, a saturating x transition counter.
module modulo_compuerta2
    import modulo_compuerta2_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int REG_OUT     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic x,
    output logic y
`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
    ,
    output logic [TOGGLE_CNT_W-1:0] x_toggles
`endif
);

    operands_t raw_s;
    operands_t core_ops_s;
    logic      x_c_s;
    logic      y_c_s;

    assign raw_s = {A, B, C, D};

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign core_ops_s = raw_s;
        end else begin : g_sync
            localparam int STAGES = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
            operands_t sync_r [STAGES];

            // Per-input synchronizer chain; all four operands move together
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        sync_r[i] <= '0;
                    end
                end else begin
                    sync_r[0] <= raw_s;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign core_ops_s = sync_r[STAGES-1];
        end
    endgenerate

    modulo_compuerta2_logic u_logic (
        .ops (core_ops_s),
        .x_c (x_c_s),
        .y_c (y_c_s)
    );

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic x_r;
            logic y_r;

            // Output registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_r <= 1'b0;
                    y_r <= 1'b0;
                end else begin
                    x_r <= x_c_s;
                    y_r <= y_c_s;
                end
            end

            assign x = x_r;
            assign y = y_r;
        end else begin : g_comb_out
            assign x = x_c_s;
            assign y = y_c_s;
        end
    endgenerate

`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
    // x_old_s is the visible x as of the previous edge; x_c_s is its value from this edge on.
    logic                    x_old_s;
    logic [TOGGLE_CNT_W-1:0] x_toggles_r;

    generate
        if (REG_OUT != 0) begin : g_old_reg
            assign x_old_s = x;
        end else begin : g_old_comb
            logic x_prev_r;

            // Remember the combinational x seen at the last edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_prev_r <= 1'b0;
                end else begin
                    x_prev_r <= x_c_s;
                end
            end

            assign x_old_s = x_prev_r;
        end
    endgenerate

    // Saturating transition counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_toggles_r <= '0;
        end else if ((x_c_s != x_old_s) && (x_toggles_r != TOGGLE_CNT_MAX)) begin
            x_toggles_r <= x_toggles_r + 8'd1;
        end
    end

    assign x_toggles = x_toggles_r;
`endif

endmodule

// File: tb/tb_modulo_compuerta2.sv
// Randomized self-checking bench: three configurations share one stimulus stream and
// are compared every cycle against an input-history model, plus literal directed checks.
module tb_modulo_compuerta2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic x_reg, y_reg, x_comb, y_comb, x_sync, y_sync;
    logic [7:0] tog_reg, tog_comb, tog_sync;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    modulo_compuerta2 #(.SYNC_STAGES(0), .REG_OUT(1)) dut_reg (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .x(x_reg), .y(y_reg)
`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
        , .x_toggles(tog_reg)
`endif
    );

    modulo_compuerta2 #(.SYNC_STAGES(0), .REG_OUT(0)) dut_comb (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .x(x_comb), .y(y_comb)
`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
        , .x_toggles(tog_comb)
`endif
    );

    modulo_compuerta2 #(.SYNC_STAGES(2), .REG_OUT(1)) dut_sync (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .x(x_sync), .y(y_sync)
`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
        , .x_toggles(tog_sync)
`endif
    );

`ifndef MODULO_COMPUERTA2_TOGGLE_CNT_EN
    assign tog_reg  = 8'd0;
    assign tog_comb = 8'd0;
    assign tog_sync = 8'd0;
`endif

    // Reference rules over a 4-bit operand word {A,B,C,D}
    function automatic logic ref_x(input logic [3:0] v);
        return ((v >> 2) == 4'd3) || ((v & 4'd3) == 4'd3);
    endfunction

    function automatic logic ref_y(input logic [3:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: operand words sampled at each edge (hist[0] newest), zero-filled by reset
    logic [3:0] hist [0:3];
    int         cnt_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= 4'd0;
            cnt_m <= 0;
        end else begin
            if ((ref_x({A, B, C, D}) != ref_x(hist[0])) && (cnt_m < 255)) cnt_m <= cnt_m + 1;
            hist[0] <= {A, B, C, D};
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("x_reg",  {7'd0, x_reg},  {7'd0, ref_x(hist[0])});
            check("y_reg",  {7'd0, y_reg},  {7'd0, ref_y(hist[0])});
            check("x_comb", {7'd0, x_comb}, {7'd0, ref_x({A, B, C, D})});
            check("y_comb", {7'd0, y_comb}, {7'd0, ref_y({A, B, C, D})});
            check("x_sync", {7'd0, x_sync}, {7'd0, ref_x(hist[2])});
            check("y_sync", {7'd0, y_sync}, {7'd0, ref_y(hist[2])});
`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
            check("tog_reg", tog_reg, cnt_m[7:0]);
`endif
        end
    end

    // Drive inputs 2 time units after the next rising edge
    task automatic drive(input logic [3:0] v);
        @(posedge clk);
        #2;
        {A, B, C, D} = v;
    endtask

    // Wait for the next rising edge and settle just past it
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] x_tab;
    logic [15:0] y_tab;
    logic [3:0]  v;

    initial begin
        x_tab = 16'b1111_1000_1000_1000;
        y_tab = 16'b0110_1001_1001_0110;

        repeat (2) @(posedge clk);
        #1;
        check("rst_x_reg",  {7'd0, x_reg},  8'd0);
        check("rst_y_reg",  {7'd0, y_reg},  8'd0);
        check("rst_x_sync", {7'd0, x_sync}, 8'd0);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Test 1
        drive(4'b0111);
        edge1();
        check("t1_x", {7'd0, x_reg}, 8'd1);
        check("t1_y", {7'd0, y_reg}, 8'd1);
        // Test 2
        #1; {A, B, C, D} = 4'b0110;
        edge1();
        check("t2a_x", {7'd0, x_reg}, 8'd0);
        check("t2a_y", {7'd0, y_reg}, 8'd0);
        #1; {A, B, C, D} = 4'b1110;
        edge1();
        check("t2b_x", {7'd0, x_reg}, 8'd1);
        check("t2b_y", {7'd0, y_reg}, 8'd1);

        // Test 3: exhaustive sweep on the combinational instance
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            drive(v);
            #1;
            check("t3_x", {7'd0, x_comb}, {7'd0, x_tab[i]});
            check("t3_y", {7'd0, y_comb}, {7'd0, y_tab[i]});
        end

        // Test 4: x through two synchronizer stages appears on the third edge
        drive(4'b0000);
        repeat (4) @(posedge clk);
        #2;
        {A, B, C, D} = 4'b1100;
        edge1();
        check("t4_e1", {7'd0, x_sync}, 8'd0);
        edge1();
        check("t4_e2", {7'd0, x_sync}, 8'd0);
        edge1();
        check("t4_e3", {7'd0, x_sync}, 8'd1);

        // Test 5: asynchronous reset between edges
        #1;
        check("t5_pre_x", {7'd0, x_reg}, 8'd1);
        rst = 1'b1;
        #1;
        check("t5_x_reg",  {7'd0, x_reg},  8'd0);
        check("t5_y_reg",  {7'd0, y_reg},  8'd0);
        check("t5_x_sync", {7'd0, x_sync}, 8'd0);
        drive(4'b1100);
        rst = 1'b0;

        // Random phase with occasional mid-stream resets
        for (int n = 0; n < 300; n++) begin
            drive(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 39) == 0) begin
                #1; rst = 1'b1;
                @(posedge clk); #2; rst = 1'b0;
            end
        end

`ifdef MODULO_COMPUERTA2_TOGGLE_CNT_EN
        // Test 6: counter saturation
        drive(4'b0000);
        rst = 1'b1;
        drive(4'b0100);
        rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            drive((n % 2 == 0) ? 4'b1100 : 4'b0100);
        end
        edge1();
        check("t6_tog_reg",  tog_reg,  8'd255);
        check("t6_tog_comb", tog_comb, 8'd255);
        check("t6_tog_sync", tog_sync, 8'd255);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/modulo_compuerta2.md
MODULO_COMPUERTA2 -- requirements
Module: modulo_compuerta2

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 0, meaning the number of input synchronizer flops per input (legal 0..3).
REQ-002 The block SHALL have parameter REG_OUT, default 1, meaning x and y are registered when 1 and combinational when 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports A, B, C, D, each input, 1 bit: gate operands.
REQ-006 The block SHALL have port x, output, 1 bit: AND-OR result.
REQ-007 The block SHALL have port y, output, 1 bit: parity result.
REQ-008 With MODULO_COMPUERTA2_TOGGLE_CNT_EN defined, the block SHALL also have port x_toggles, output, 8 bits: count of x transitions.

Function
REQ-009 Core logic SHALL compute x_c = (A AND B) OR (C AND D).
REQ-010 Core logic SHALL compute y_c = A XOR B XOR C XOR D.
REQ-011 Each input SHALL pass through SYNC_STAGES flops before the core; 0 means a direct connection.
REQ-012 With REG_OUT=1, x and y SHALL be the core results registered once; total latency is SYNC_STAGES+1 cycles.
REQ-013 With REG_OUT=0, x and y SHALL equal the core results combinationally; latency is SYNC_STAGES cycles (0 means the same cycle).
REQ-014 Input changes between clock edges SHALL NOT affect registered outputs until the next rising edge.
REQ-015 x_toggles SHALL increment by 1 on every clock edge where the registered or visible x differs from its previous-cycle value.
REQ-016 x_toggles SHALL saturate at 255 and never wrap.
REQ-017 Simultaneous changes on any combination of inputs SHALL be evaluated as one new operand set.

Reset
REQ-018 rst high SHALL asynchronously clear all synchronizer flops, output registers and x_toggles to 0.
REQ-019 During reset, registered x and y SHALL read 0.
REQ-020 After rst deasserts, outputs SHALL reflect inputs sampled from the first rising edge onward, with latency per REQ-012/REQ-013.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight pipeline values.

Configuration
REQ-022 Macro MODULO_COMPUERTA2_TOGGLE_CNT_EN SHALL compile in the x_toggles port and its counter.
REQ-023 Without the macro, the port and the counter logic SHALL be absent; x and y behaviour SHALL be identical in both builds.

Structure
REQ-024 Package modulo_compuerta2_pkg SHALL hold SYNC_STAGES_MAX (3), TOGGLE_CNT_W (8) and TOGGLE_CNT_MAX (255).
REQ-025 Sub-module modulo_compuerta2_logic SHALL contain only the combinational x_c/y_c equations; the top holds the synchronizers, output registers and counter.

Verification
REQ-026 Test 1: defaults; A=0, B=1, C=1, D=1 -> after 1 edge, x=1, y=1.
REQ-027 Test 2: then D=0 -> after 1 edge, x=0, y=0; then A=1 -> after 1 edge, x=1, y=1.
REQ-028 Test 3: exhaustive 16-vector sweep with REG_OUT=0 and SYNC_STAGES=0 -> x and y match REQ-009/REQ-010 in the same cycle.
REQ-029 Test 4: SYNC_STAGES=2, REG_OUT=1; step A=B=1 -> x rises exactly 3 edges later.
REQ-030 Test 5: assert rst asynchronously mid-stream with x=1 -> x=y=0 immediately, before any clock edge.
REQ-031 Test 6: with the macro defined, toggle A, keeping B=1 and C=D=0, every cycle for 300 cycles -> x_toggles stops at 255.
